// File: rtl/ex_lsu_req_if.sv
// Memory-side request bus between the EX load/store issuer and its two targets
// (Dcache and the peripheral bus controller). Ready lines are one-cycle completion pulses.
interface ex_lsu_req_if;
  logic        Dcache_req;
  logic        bc_bus_req;
  logic        lsu_rw;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        Dcache_ready;
  logic        bc_bus_ready;

  modport master (
    output Dcache_req, bc_bus_req, lsu_rw, lsu_addr, lsu_wdata, lsu_wstrb,
    input  Dcache_ready, bc_bus_ready
  );

  modport slave (
    input  Dcache_req, bc_bus_req, lsu_rw, lsu_addr, lsu_wdata, lsu_wstrb,
    output Dcache_ready, bc_bus_ready
  );
endinterface

// File: rtl/ex_lsu_req.sv
// EX-stage load/store request issuer: routes to Dcache or peripheral bus, lane-aligns stores and holds
// the request until the target's ready pulse. Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module ex_lsu_req #(
`ifdef LSU_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 16,
`endif
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
  parameter logic [31:0] PERIPH_MASK = 32'hF000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_mtype_i,
  input  logic               ex_mem_rw_i,
  input  logic [1:0]         ex_mem_width_i,
  input  logic [31:0]        ex_mem_addr_i,
  input  logic [31:0]        ex_mem_wdata_i,
  input  logic               fc_stall_ex_i,
  input  logic               fc_flush_ex_i,
  ex_lsu_req_if.master       bus,
  output logic               lsu_stall_o,
  output logic               lsu_misalign_o,
  output logic               lsu_bus_err_o
);

  typedef enum logic [1:0] {IDLE, DC_WAIT, BUS_WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic        drop_reg, drop_next;
  logic        rw_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  wstrb_reg;

  logic        aligned, op_valid, launch, misalign_hit, is_periph, in_wait, timeout;
  logic [3:0]  wstrb_dec;
  logic [31:0] wdata_dec;

  always_comb begin
    wstrb_dec = 4'b0000;
    wdata_dec = ex_mem_wdata_i;
    aligned   = 1'b0;
    case (ex_mem_width_i)
      2'b01: begin
        wstrb_dec = 4'b0001 << ex_mem_addr_i[1:0];
        wdata_dec = {4{ex_mem_wdata_i[7:0]}};
        aligned   = 1'b1;
      end
      2'b10: begin
        wstrb_dec = 4'b0011 << {ex_mem_addr_i[1], 1'b0};
        wdata_dec = {2{ex_mem_wdata_i[15:0]}};
        aligned   = !ex_mem_addr_i[0];
      end
      2'b11: begin
        wstrb_dec = 4'b1111;
        aligned   = (ex_mem_addr_i[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  // Width 00 is a silent no-op: it neither launches nor flags misalignment.
  assign op_valid     = ex_mtype_i && !fc_flush_ex_i && (ex_mem_width_i != 2'b00);
  assign launch       = (state_reg == IDLE) && op_valid && aligned;
  assign misalign_hit = (state_reg == IDLE) && op_valid && !aligned;
  assign is_periph    = ((ex_mem_addr_i & PERIPH_MASK) == PERIPH_BASE);
  assign in_wait      = (state_reg == DC_WAIT) || (state_reg == BUS_WAIT);

`ifdef LSU_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_reg;

  // Counter reaching the limit means TIMEOUT_CYCLES request cycles went by unanswered.
  assign timeout = in_wait && (wdog_reg == WDOG_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n || launch) begin
      wdog_reg <= '0;
    end else if (in_wait && !timeout) begin
      wdog_reg <= wdog_reg + WDOG_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      drop_reg  <= 1'b0;
      rw_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
    end else begin
      state_reg <= state_next;
      drop_reg  <= drop_next;
      if (launch) begin
        rw_reg    <= ex_mem_rw_i;
        addr_reg  <= {ex_mem_addr_i[31:2], 2'b00};
        wdata_reg <= wdata_dec;
        wstrb_reg <= ex_mem_rw_i ? wstrb_dec : 4'b0000;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    drop_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next = is_periph ? BUS_WAIT : DC_WAIT;
        end else if (misalign_hit) begin
          state_next = fc_stall_ex_i ? DONE : IDLE;
        end
      end
      DC_WAIT, BUS_WAIT: begin
        if (timeout) begin
          state_next = IDLE;
        end else if ((state_reg == DC_WAIT) ? bus.Dcache_ready : bus.bc_bus_ready) begin
          // A flushed op has already left EX, so there is nothing to park in DONE.
          state_next = (drop_reg || fc_flush_ex_i || !fc_stall_ex_i) ? IDLE : DONE;
        end else begin
          drop_next = drop_reg || fc_flush_ex_i;
        end
      end
      DONE: begin
        if (fc_flush_ex_i || !fc_stall_ex_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.Dcache_req = 1'b0;
    bus.bc_bus_req = 1'b0;
    lsu_stall_o    = 1'b0;
    lsu_misalign_o = 1'b0;
    lsu_bus_err_o  = 1'b0;
    case (state_reg)
      IDLE: begin
        lsu_stall_o    = launch;
        lsu_misalign_o = misalign_hit;
      end
      DC_WAIT: begin
        bus.Dcache_req = !timeout;
        lsu_stall_o    = !timeout && !bus.Dcache_ready;
        lsu_bus_err_o  = timeout;
      end
      BUS_WAIT: begin
        bus.bc_bus_req = !timeout;
        lsu_stall_o    = !timeout && !bus.bc_bus_ready;
        lsu_bus_err_o  = timeout;
      end
      default: ;
    endcase
  end

  assign bus.lsu_rw    = rw_reg;
  assign bus.lsu_addr  = addr_reg;
  assign bus.lsu_wdata = wdata_reg;
  assign bus.lsu_wstrb = wstrb_reg;

endmodule
